// File: rtl/frame_filler.sv
// frame_filler: pads every input line to exactly H_DISP pixels with a programmable fill
// colour and truncates longer lines. In mode 2 it also pads or truncates each frame to
// exactly V_DISP lines before regenerating VSYNC. Reports per-line and per-frame geometry.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-high reset
//   en           enable; 0 selects registered bypass (latched at frame start)
//   mode         0 bypass, 1 horizontal, 2 horizontal+vertical, 3 same as 1
//   fill_color   colour driven on generated pixels
//   pre_vs       input vsync, active high
//   pre_de       input data enable
//   pre_data     input pixel
//   post_vs      output vsync
//   post_de      output data enable
//   post_data    output pixel
//   line_len     pixel count of last completed input line (saturating)
//   frame_lines  input line count of last frame (saturating)
//   ovf          sticky error flag (new line during padding, pixels during VPAD/VS_OUT)
module frame_filler #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned H_DISP = 1280,
  parameter int unsigned V_DISP = 720,
  parameter int unsigned H_GAP  = 16,
  parameter int unsigned VS_W   = 4,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_color,
  input  logic              pre_vs,
  input  logic              pre_de,
  input  logic [DATA_W-1:0] pre_data,
  output logic              post_vs,
  output logic              post_de,
  output logic [DATA_W-1:0] post_data,
  output logic [CNT_W-1:0]  line_len,
  output logic [CNT_W-1:0]  frame_lines,
  output logic              ovf
);

  localparam logic [2:0] StLine    = 3'd0;
  localparam logic [2:0] StHpad    = 3'd1;
  localparam logic [2:0] StVpadDe  = 3'd2;
  localparam logic [2:0] StVpadGap = 3'd3;
  localparam logic [2:0] StVsOut   = 3'd4;

  localparam logic [CNT_W-1:0] HDisp   = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] HLast   = CNT_W'(H_DISP - 1);
  localparam logic [CNT_W-1:0] VDisp   = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(H_GAP - 1);
  localparam logic [CNT_W-1:0] VsLast  = CNT_W'(VS_W - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              vs_q, de_q;
  logic [CNT_W-1:0]  x_q, x_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  out_lines_q, out_lines_d;
  logic [CNT_W-1:0]  in_lines_q, in_lines_d;
  logic [CNT_W-1:0]  line_len_q, line_len_d;
  logic [CNT_W-1:0]  frame_lines_q, frame_lines_d;
  logic              ovf_q, ovf_d;
  logic              post_vs_q, post_vs_d;
  logic              post_de_q, post_de_d;
  logic [DATA_W-1:0] post_data_q, post_data_d;

  logic             vs_rise, de_rise, de_fall;
  logic             vs_live, vs_acc;
  logic             pad_mode, vpad_mode, lines_full, drop_line;
  logic [1:0]       mode_in;
  logic [CNT_W-1:0] out_lines_inc;

  assign vs_rise   = pre_vs & ~vs_q;
  assign de_rise   = pre_de & ~de_q;
  assign de_fall   = ~pre_de & de_q;
  // pre_vs is only honoured while forwarding lines; VPAD and VS_OUT ignore it.
  assign vs_live   = (state_q == StLine) || (state_q == StHpad);
  assign vs_acc    = vs_rise & vs_live;
  assign pad_mode  = (mode_q != 2'd0);
  assign vpad_mode = (mode_q == 2'd2);
  assign mode_in   = en ? mode : 2'd0;

  assign lines_full    = (out_lines_q == VDisp);
  assign out_lines_inc = lines_full ? out_lines_q : out_lines_q + 1'b1;
  // Vertical truncation: once a full frame has been emitted, whole lines are discarded.
  assign drop_line     = vpad_mode & lines_full;

  // Input geometry: pixel index within the line and line count within the frame.
  always_comb begin
    x_d           = x_q;
    line_len_d    = line_len_q;
    in_lines_d    = in_lines_q;
    frame_lines_d = frame_lines_q;

    if (pre_vs || !pre_de) begin
      x_d = '0;
    end else if (x_q != CntMax) begin
      x_d = x_q + 1'b1;
    end

    if (de_fall) begin
      line_len_d = x_q;
    end

    if (vs_acc) begin
      frame_lines_d = in_lines_q;
      in_lines_d    = '0;
    end
    if (de_rise && (in_lines_d != CntMax)) begin
      in_lines_d = in_lines_d + 1'b1;
    end
  end

  // Output sequencing.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    hcnt_d      = hcnt_q;
    out_lines_d = out_lines_q;
    ovf_d       = ovf_q;
    post_vs_d   = 1'b0;
    post_de_d   = 1'b0;
    post_data_d = '0;

    unique case (state_q)
      StLine, StHpad: begin
        if (vs_acc) begin
          // Frame boundary: close the current frame under the mode it was started with.
          mode_d = mode_in;
          if (!en) begin
            ovf_d = 1'b0;
          end
          if (vpad_mode && (out_lines_q != '0) && !lines_full) begin
            state_d = StVpadDe;
            hcnt_d  = '0;
          end else begin
            state_d     = StLine;
            out_lines_d = '0;
            post_vs_d   = pre_vs;
            if (!pad_mode) begin
              post_de_d   = pre_de;
              post_data_d = pre_data;
            end
          end
        end else if ((state_q == StHpad) && !de_rise) begin
          post_de_d   = 1'b1;
          post_data_d = fill_color;
          hcnt_d      = hcnt_q + 1'b1;
          if (hcnt_q == HLast) begin
            state_d     = StLine;
            out_lines_d = out_lines_inc;
          end
        end else begin
          // A new line arriving while padding abandons the pad.
          if (state_q == StHpad) begin
            ovf_d = 1'b1;
          end
          state_d   = StLine;
          post_vs_d = pre_vs;
          if (!pad_mode) begin
            post_de_d   = pre_de;
            post_data_d = pre_data;
          end else if (pre_de) begin
            if ((x_q < HDisp) && !drop_line) begin
              post_de_d   = 1'b1;
              post_data_d = pre_data;
              if (x_q == HLast) begin
                out_lines_d = out_lines_inc;
              end
            end
          end else if (de_fall && (x_q < HDisp) && !drop_line) begin
            // First pad pixel goes out in the fall cycle so the stream stays contiguous.
            post_de_d   = 1'b1;
            post_data_d = fill_color;
            if (x_q == HLast) begin
              out_lines_d = out_lines_inc;
            end else begin
              state_d = StHpad;
              hcnt_d  = x_q + 1'b1;
            end
          end
        end
      end

      StVpadDe: begin
        post_de_d   = 1'b1;
        post_data_d = fill_color;
        if (pre_de) begin
          ovf_d = 1'b1;
        end
        if (hcnt_q == HLast) begin
          state_d     = StVpadGap;
          hcnt_d      = '0;
          out_lines_d = out_lines_inc;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      StVpadGap: begin
        if (pre_de) begin
          ovf_d = 1'b1;
        end
        if (hcnt_q == GapLast) begin
          hcnt_d  = '0;
          state_d = lines_full ? StVsOut : StVpadDe;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      StVsOut: begin
        post_vs_d = 1'b1;
        if (pre_de) begin
          ovf_d = 1'b1;
        end
        if (hcnt_q == VsLast) begin
          hcnt_d      = '0;
          out_lines_d = '0;
          state_d     = StLine;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StLine;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StLine;
      mode_q        <= 2'd0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      x_q           <= '0;
      hcnt_q        <= '0;
      out_lines_q   <= '0;
      in_lines_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      ovf_q         <= 1'b0;
      post_vs_q     <= 1'b0;
      post_de_q     <= 1'b0;
      post_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      vs_q          <= pre_vs;
      de_q          <= pre_de;
      x_q           <= x_d;
      hcnt_q        <= hcnt_d;
      out_lines_q   <= out_lines_d;
      in_lines_q    <= in_lines_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      ovf_q         <= ovf_d;
      post_vs_q     <= post_vs_d;
      post_de_q     <= post_de_d;
      post_data_q   <= post_data_d;
    end
  end

  assign post_vs     = post_vs_q;
  assign post_de     = post_de_q;
  assign post_data   = post_data_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_frame_filler.sv
// Directed bench for frame_filler with a one-entry-per-cycle expected-output scoreboard.
module tb_frame_filler;

  localparam int unsigned DW = 24;
  localparam logic [DW-1:0] Fill = 24'hFF00FF;

  typedef struct packed {
    logic          vs;
    logic          de;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk, rst, en;
  logic [1:0]    mode;
  logic [DW-1:0] fill_color, pre_data, post_data;
  logic          pre_vs, pre_de, post_vs, post_de, ovf;
  logic [11:0]   line_len, frame_lines;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  frame_filler #(
    .DATA_W(24), .H_DISP(8), .V_DISP(4), .H_GAP(2), .VS_W(2), .CNT_W(12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .fill_color (fill_color),
    .pre_vs     (pre_vs),
    .pre_de     (pre_de),
    .pre_data   (pre_data),
    .post_vs    (post_vs),
    .post_de    (post_de),
    .post_data  (post_data),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one cycle of input, then compare the previous cycle's expectation (now visible
  // on the registered outputs) and queue this cycle's expectation.
  task automatic step(input logic vs, input logic de, input logic [DW-1:0] d,
                      input logic evs, input logic ede, input logic [DW-1:0] ed);
    exp_t e, n;
    @(posedge clk);
    #1;
    pre_vs   = vs;
    pre_de   = de;
    pre_data = d;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("post_vs@%0d", cyc), {31'd0, post_vs}, {31'd0, e.vs});
      chk($sformatf("post_de@%0d", cyc), {31'd0, post_de}, {31'd0, e.de});
      if (e.de) chk($sformatf("post_data@%0d", cyc), {8'd0, post_data}, {8'd0, e.data});
    end
    n.vs = evs; n.de = ede; n.data = ed;
    exp_q.push_back(n);
    cyc++;
  endtask

  task automatic px(input logic [DW-1:0] d, input logic ede, input logic [DW-1:0] ed);
    step(1'b0, 1'b1, d, 1'b0, ede, ed);
  endtask

  task automatic idle(input logic ede, input logic [DW-1:0] ed);
    step(1'b0, 1'b0, '0, 1'b0, ede, ed);
  endtask

  // Two-cycle vsync pulse expected to be passed through with one cycle of latency.
  task automatic vs_pass();
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [DW-1:0] dpx(input int i);
    return 24'h100000 + DW'(i);
  endfunction

  function automatic logic [DW-1:0] epx(input int i);
    return 24'h200000 + DW'(i);
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'd1; fill_color = Fill;
    pre_vs = 1'b0; pre_de = 1'b0; pre_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst post_vs", {31'd0, post_vs}, 0);
    chk("rst post_de", {31'd0, post_de}, 0);
    chk("rst post_data", {8'd0, post_data}, 0);
    chk("rst line_len", {20'd0, line_len}, 0);
    chk("rst frame_lines", {20'd0, frame_lines}, 0);
    chk("rst ovf", {31'd0, ovf}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latch mode 1 (bypass frame closes).
    vs_pass();

    // 5-pixel line: 5 data then 3 fill pixels, contiguous.
    for (int i = 0; i < 5; i++) px(dpx(i), 1'b1, dpx(i));
    for (int i = 0; i < 3; i++) idle(1'b1, Fill);
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("line_len 5", {20'd0, line_len}, 5);

    // 11-pixel line: only the first 8 pass.
    for (int i = 0; i < 11; i++) px(dpx(i), (i < 8), dpx(i));
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("line_len 11", {20'd0, line_len}, 11);

    // Short line, new line two cycles after the fall aborts the pad.
    for (int i = 0; i < 5; i++) px(dpx(i), 1'b1, dpx(i));
    idle(1'b1, Fill);
    idle(1'b1, Fill);
    for (int i = 0; i < 8; i++) px(epx(i), 1'b1, epx(i));
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("ovf abort", {31'd0, ovf}, 1);

    // Latch en=0: clears ovf; frame had 4 input lines.
    en = 1'b0;
    vs_pass();
    chk("ovf cleared", {31'd0, ovf}, 0);
    chk("frame_lines 4", {20'd0, frame_lines}, 4);

    // Latch mode 2 (bypass frame with no lines closes).
    en = 1'b1; mode = 2'd2;
    vs_pass();
    chk("frame_lines 0", {20'd0, frame_lines}, 0);

    // Mode 2: two lines then vsync -> two generated lines, gaps, regenerated vsync.
    for (int i = 0; i < 8; i++) px(dpx(i), 1'b1, dpx(i));
    idle(1'b0, '0);
    idle(1'b0, '0);
    for (int i = 0; i < 5; i++) px(epx(i), 1'b1, epx(i));
    for (int i = 0; i < 3; i++) idle(1'b1, Fill);
    idle(1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, Fill);
    for (int i = 0; i < 7; i++) idle(1'b1, Fill);
    for (int i = 0; i < 2; i++) idle(1'b0, '0);
    for (int i = 0; i < 8; i++) idle(1'b1, Fill);
    for (int i = 0; i < 2; i++) idle(1'b0, '0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    idle(1'b0, '0);
    idle(1'b0, '0);
    chk("frame_lines 2", {20'd0, frame_lines}, 2);

    // Mode 2: six lines, last two dropped, vsync passed straight through. Latch mode 1.
    mode = 2'd1;
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < 8; i++) px(dpx(i), (l < 4), dpx(i));
      idle(1'b0, '0);
    end
    vs_pass();
    chk("frame_lines 6", {20'd0, frame_lines}, 6);

    // Mid-frame switch to bypass: padding persists until the next vsync.
    mode = 2'd0;
    for (int i = 0; i < 5; i++) px(dpx(i), 1'b1, dpx(i));
    for (int i = 0; i < 3; i++) idle(1'b1, Fill);
    idle(1'b0, '0);
    chk("line_len pad", {20'd0, line_len}, 5);
    vs_pass();
    for (int i = 0; i < 5; i++) px(epx(i), 1'b1, epx(i));
    for (int i = 0; i < 3; i++) idle(1'b0, '0);
    chk("line_len bypass", {20'd0, line_len}, 5);

    // Reset pulse during horizontal padding.
    mode = 2'd1;
    vs_pass();
    for (int i = 0; i < 5; i++) px(dpx(i), 1'b1, dpx(i));
    idle(1'b1, Fill);
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("arst post_vs", {31'd0, post_vs}, 0);
    chk("arst post_de", {31'd0, post_de}, 0);
    chk("arst post_data", {8'd0, post_data}, 0);
    chk("arst line_len", {20'd0, line_len}, 0);
    chk("arst frame_lines", {20'd0, frame_lines}, 0);
    chk("arst ovf", {31'd0, ovf}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) idle(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
